// File: rtl/fp_mant_normalizer_pkg.sv
// Shared types and constants for the floating-point mantissa normalizer.
// Holds the control state encoding and the saturating exponent limit helper.
package fp_norm_pkg;

    // Control states: waiting for a sum, shifting, holding the result.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NORM = 2'd1,
        ST_DONE = 2'd2
    } norm_state_t;

    // Largest representable biased exponent for an ew-bit exponent field.
    function automatic int exp_max(input int ew);
        return (1 << ew) - 1;
    endfunction

endpackage

// File: rtl/fp_mant_normalizer_if.sv
// Handshake bundle between the mantissa adder, the normalizer and the
// rounding/pack stage. Optional macro FP_NORM_STICKY_EN adds sticky_out.
//
// Handshake rule (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high; a producer holds valid and its payload
// steady until that edge, and ready never depends on the same cycle's valid.
interface fp_mant_normalizer_if #(
    parameter int N  = 24,
    parameter int EW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  mant_in;
    logic          c_out_in;
    logic [EW-1:0] exp_in;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  mant_out;
    logic [EW-1:0] exp_out;
    logic          zero_out;
    logic          ovf_out;
    logic          unf_out;
`ifdef FP_NORM_STICKY_EN
    logic          sticky_out;
`endif

    // Environment side: supplies sums, consumes results.
    modport master (
        output in_valid, mant_in, c_out_in, exp_in, out_ready,
        input  in_ready, out_valid, mant_out, exp_out, zero_out, ovf_out, unf_out
`ifdef FP_NORM_STICKY_EN
        , input sticky_out
`endif
    );

    // Normalizer side.
    modport slave (
        input  in_valid, mant_in, c_out_in, exp_in, out_ready,
        output in_ready, out_valid, mant_out, exp_out, zero_out, ovf_out, unf_out
`ifdef FP_NORM_STICKY_EN
        , output sticky_out
`endif
    );

endinterface

// File: rtl/fp_mant_normalizer_step.sv
// One normalization step: decides, from the current working values, whether
// the result is final (carry, zero, normalized, underflow) or needs one more
// left shift. Optional macro FP_NORM_STICKY_EN exposes the bit lost by the
// carry right-shift.
module fp_norm_step
    import fp_norm_pkg::*;
#(
    parameter int N  = 24,
    parameter int EW = 8
) (
    input  logic [N-1:0]  mant,
    input  logic [EW-1:0] exp,
    input  logic          c,
    output logic [N-1:0]  mant_nxt,
    output logic [EW-1:0] exp_nxt,
    output logic          fin,
    output logic          zero,
    output logic          ovf,
    output logic          unf
`ifdef FP_NORM_STICKY_EN
    , output logic        lost_bit
`endif
);

    localparam logic [EW-1:0] EMAX = EW'(exp_max(EW));
    localparam logic [EW-1:0] ONE  = EW'(1);

    // Priority: carry, zero, already normalized, underflow, else shift left.
    always_comb begin
        mant_nxt = mant;
        exp_nxt  = exp;
        fin      = 1'b0;
        zero     = 1'b0;
        ovf      = 1'b0;
        unf      = 1'b0;
`ifdef FP_NORM_STICKY_EN
        lost_bit = 1'b0;
`endif
        if (c) begin
            fin = 1'b1;
`ifdef FP_NORM_STICKY_EN
            lost_bit = mant[0];
`endif
            // Saturate instead of wrapping; >= also covers an input already at EMAX.
            if (exp >= EMAX - ONE) begin
                ovf      = 1'b1;
                exp_nxt  = EMAX;
                mant_nxt = '0;
            end else begin
                mant_nxt = {1'b1, mant[N-1:1]};
                exp_nxt  = exp + ONE;
            end
        end else if (mant == '0) begin
            fin     = 1'b1;
            zero    = 1'b1;
            exp_nxt = '0;
        end else if (mant[N-1]) begin
            fin = 1'b1;
        end else if (exp <= ONE) begin
            fin     = 1'b1;
            unf     = 1'b1;
            exp_nxt = '0;
        end else begin
            mant_nxt = mant << 1;
            exp_nxt  = exp - ONE;
        end
    end

endmodule

// File: rtl/fp_mant_normalizer.sv
// Iterative mantissa normalizer: accepts the adder sum, shifts one position
// per cycle until normalized, then presents mantissa, exponent and flags.
// Optional macro FP_NORM_STICKY_EN adds sticky_out on the interface.
module fp_mant_normalizer
    import fp_norm_pkg::*;
#(
    parameter int N  = 24,
    parameter int EW = 8
) (
    input  logic                clk,
    input  logic                rst,
    fp_mant_normalizer_if.slave bus,
    output norm_state_t         state_dbg
);

    norm_state_t   state, state_nxt;
    logic [N-1:0]  mant_r, mant_o;
    logic [EW-1:0] exp_r, exp_o;
    logic          c_r;
    logic          fin_r;
    logic          zero_o, ovf_o, unf_o;
    logic          accept;
    logic [N-1:0]  step_mant;
    logic [EW-1:0] step_exp;
    logic          step_fin, step_zero, step_ovf, step_unf;
`ifdef FP_NORM_STICKY_EN
    logic          step_lost;
    logic          sticky_o;
`endif

    assign accept = (state == ST_IDLE) && bus.in_valid;

    fp_norm_step #(.N(N), .EW(EW)) u_step (
        .mant     (mant_r),
        .exp      (exp_r),
        .c        (c_r),
        .mant_nxt (step_mant),
        .exp_nxt  (step_exp),
        .fin      (step_fin),
        .zero     (step_zero),
        .ovf      (step_ovf),
        .unf      (step_unf)
`ifdef FP_NORM_STICKY_EN
        , .lost_bit (step_lost)
`endif
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next state: fin_r marks that the final step has been latched, which
    // adds the one cycle between the deciding step and out_valid.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.in_valid) state_nxt = ST_NORM;
            ST_NORM: if (fin_r)        state_nxt = ST_DONE;
            ST_DONE: if (bus.out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Handshake outputs are pure functions of the state.
    always_comb begin
        bus.in_ready  = (state == ST_IDLE);
        bus.out_valid = (state == ST_DONE);
    end

    // Working registers and result registers; accept clears the old result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mant_r <= '0;
            exp_r  <= '0;
            c_r    <= 1'b0;
            fin_r  <= 1'b0;
            mant_o <= '0;
            exp_o  <= '0;
            zero_o <= 1'b0;
            ovf_o  <= 1'b0;
            unf_o  <= 1'b0;
`ifdef FP_NORM_STICKY_EN
            sticky_o <= 1'b0;
`endif
        end else if (accept) begin
            mant_r <= bus.mant_in;
            exp_r  <= bus.exp_in;
            c_r    <= bus.c_out_in;
            fin_r  <= 1'b0;
            mant_o <= '0;
            exp_o  <= '0;
            zero_o <= 1'b0;
            ovf_o  <= 1'b0;
            unf_o  <= 1'b0;
`ifdef FP_NORM_STICKY_EN
            sticky_o <= 1'b0;
`endif
        end else if ((state == ST_NORM) && !fin_r) begin
            mant_r <= step_mant;
            exp_r  <= step_exp;
            if (step_fin) begin
                fin_r  <= 1'b1;
                c_r    <= 1'b0;
                mant_o <= step_mant;
                exp_o  <= step_exp;
                zero_o <= step_zero;
                ovf_o  <= step_ovf;
                unf_o  <= step_unf;
`ifdef FP_NORM_STICKY_EN
                sticky_o <= step_lost;
`endif
            end
        end
    end

    assign bus.mant_out = mant_o;
    assign bus.exp_out  = exp_o;
    assign bus.zero_out = zero_o;
    assign bus.ovf_out  = ovf_o;
    assign bus.unf_out  = unf_o;
`ifdef FP_NORM_STICKY_EN
    assign bus.sticky_out = sticky_o;
`endif
    assign state_dbg = state;

endmodule

// File: tb/tb_fp_mant_normalizer.sv
// Directed bench for fp_mant_normalizer with an arithmetic reference model,
// an expected-result queue and a per-cycle output compare.
module tb_fp_mant_normalizer;
    import fp_norm_pkg::*;

    localparam int N  = 24;
    localparam int EW = 8;
    localparam int W  = N + EW + 4;
`ifdef FP_NORM_STICKY_EN
    localparam logic [W-1:0] CMP_MASK = {W{1'b1}};
`else
    localparam logic [W-1:0] CMP_MASK = {{(W-1){1'b1}}, 1'b0};
`endif

    typedef struct {
        logic [N-1:0]  mant;
        logic          c;
        logic [EW-1:0] e;
        logic [N-1:0]  rm;
        logic [EW-1:0] re;
        logic          z, o, u, s;
        int            k;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    fp_mant_normalizer_if #(.N(N), .EW(EW)) bus ();
    norm_state_t state_dbg;

    fp_mant_normalizer #(.N(N), .EW(EW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    logic dut_sticky;
`ifdef FP_NORM_STICKY_EN
    assign dut_sticky = bus.sticky_out;
`else
    assign dut_sticky = 1'b0;
`endif

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    int lat_q[$];
    int acc_q[$];
    bit seen = 1'b0;
    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Reference: count leading zeros, limit shifts by the exponent headroom.
    function automatic logic [W-1:0] model(input logic [N-1:0] m, input logic c,
                                           input logic [EW-1:0] e, output int k);
        logic [N-1:0]  rm;
        logic [EW-1:0] re;
        logic z, o, u, s;
        int msb, lz, allowed, emax;
        emax = (1 << EW) - 1;
        rm = m; re = e; z = 0; o = 0; u = 0; s = 0; k = 0;
        if (c) begin
            s = m[0];
            if (int'(e) + 1 >= emax) begin
                o = 1; re = EW'(emax); rm = '0;
            end else begin
                rm = m >> 1; rm[N-1] = 1'b1; re = e + EW'(1);
            end
        end else if (m == '0) begin
            z = 1; re = '0;
        end else begin
            msb = 0;
            for (int i = 0; i < N; i++) if (m[i]) msb = i;
            lz = N - 1 - msb;
            allowed = (int'(e) > 1) ? int'(e) - 1 : 0;
            if (lz <= allowed) begin
                k = lz; rm = m << lz; re = EW'(int'(e) - lz);
            end else begin
                k = allowed; rm = m << allowed; re = '0; u = 1;
            end
        end
        return {rm, re, z, o, u, s};
    endfunction

    // Compare process: every cycle out_valid is high the result must match
    // the queue head, and the first such cycle must land at accept + k + 2.
    always @(negedge clk) begin
        logic [W-1:0] got;
        if (rst) begin
            seen = 1'b0;
        end else if (bus.out_valid) begin
            got = {bus.mant_out, bus.exp_out, bus.zero_out, bus.ovf_out, bus.unf_out, dut_sticky};
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 64'(bus.out_valid), 64'd0);
            end else begin
                check("result", 64'(got & CMP_MASK), 64'(exp_q[0] & CMP_MASK));
                check("in_ready_in_done", 64'(bus.in_ready), 64'd0);
                if (!seen) begin
                    check("latency", 64'(cycle - acc_q[0]), 64'(lat_q[0]));
                    seen = 1'b1;
                end
                if (bus.out_ready) begin
                    void'(exp_q.pop_front());
                    void'(lat_q.pop_front());
                    void'(acc_q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_txn(input vec_t v, input logic [W-1:0] want, input int k);
        int t;
        @(posedge clk); #1;
        bus.mant_in = v.mant; bus.c_out_in = v.c; bus.exp_in = v.e; bus.in_valid = 1'b1;
        for (t = 0; t < 100; t++) begin
            @(negedge clk);
            if (bus.in_ready) break;
        end
        if (t == 100) check("in_ready_timeout", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        exp_q.push_back(want);
        lat_q.push_back(k + 2);
        acc_q.push_back(cycle);
    endtask

    task automatic wait_done();
        int t;
        for (t = 0; t < 100; t++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            check("done_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete(); lat_q.delete(); acc_q.delete();
        end
    endtask

    task automatic run_vec(input int i, input bit hold);
        vec_t v;
        logic [W-1:0] want;
        int k, t;
        v = vecs[i];
        want = model(v.mant, v.c, v.e, k);
        check($sformatf("model_vec%0d", i), 64'(want), 64'({v.rm, v.re, v.z, v.o, v.u, v.s}));
        check($sformatf("model_k%0d", i), 64'(k), 64'(v.k));
        if (hold) bus.out_ready = 1'b0;
        start_txn(v, want, k);
        if (hold) begin
            for (t = 0; t < 100; t++) begin
                @(negedge clk);
                if (bus.out_valid) break;
            end
            check("hold_reach_valid", 64'(bus.out_valid), 64'd1);
            repeat (5) begin
                @(negedge clk);
                check("hold_valid", 64'(bus.out_valid), 64'd1);
                check("hold_in_ready", 64'(bus.in_ready), 64'd0);
            end
            @(posedge clk); #1;
            bus.out_ready = 1'b1;
        end
        wait_done();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_mant"}, 64'(bus.mant_out), 64'd0);
        check({tag, "_exp"}, 64'(bus.exp_out), 64'd0);
        check({tag, "_flags"}, 64'({bus.zero_out, bus.ovf_out, bus.unf_out, dut_sticky}), 64'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        //                mant        c     exp     res mant    res exp  z     o     u     s     k
        vecs[0]  = '{24'h800000, 1'b0, 8'd100, 24'h800000, 8'd100, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs[1]  = '{24'h000001, 1'b1, 8'd100, 24'h800000, 8'd101, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        vecs[2]  = '{24'h000F00, 1'b0, 8'd100, 24'hF00000, 8'd88,  1'b0, 1'b0, 1'b0, 1'b0, 12};
        vecs[3]  = '{24'h000000, 1'b0, 8'd50,  24'h000000, 8'd0,   1'b1, 1'b0, 1'b0, 1'b0, 0};
        vecs[4]  = '{24'h123457, 1'b1, 8'd254, 24'h000000, 8'd255, 1'b0, 1'b1, 1'b0, 1'b1, 0};
        vecs[5]  = '{24'h000001, 1'b0, 8'd3,   24'h000004, 8'd0,   1'b0, 1'b0, 1'b1, 1'b0, 2};
        vecs[6]  = '{24'h400000, 1'b0, 8'd2,   24'h800000, 8'd1,   1'b0, 1'b0, 1'b0, 1'b0, 1};
        vecs[7]  = '{24'h400000, 1'b0, 8'd1,   24'h400000, 8'd0,   1'b0, 1'b0, 1'b1, 1'b0, 0};
        vecs[8]  = '{24'hFFFFFF, 1'b1, 8'd10,  24'hFFFFFF, 8'd11,  1'b0, 1'b0, 1'b0, 1'b1, 0};
        vecs[9]  = '{24'h000001, 1'b0, 8'd200, 24'h800000, 8'd177, 1'b0, 1'b0, 1'b0, 1'b0, 23};
        vecs[10] = '{24'h000ABC, 1'b1, 8'd255, 24'h000000, 8'd255, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        vecs[11] = '{24'h000010, 1'b0, 8'd0,   24'h000010, 8'd0,   1'b0, 1'b0, 1'b1, 1'b0, 0};

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.mant_in = '0; bus.c_out_in = 1'b0; bus.exp_in = '0;
        bus.out_ready = 1'b1;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(i, i == 5);

        // Abort a multi-shift operation part way through.
        begin
            logic [W-1:0] want;
            int k;
            want = model(vecs[2].mant, vecs[2].c, vecs[2].e, k);
            start_txn(vecs[2], want, k);
            repeat (5) @(posedge clk);
            #2 rst = 1'b1;
            #1;
            check_reset_outputs("mid_reset");
            exp_q.delete(); lat_q.delete(); acc_q.delete();
            @(negedge clk);
            check_reset_outputs("mid_reset_hold");
            @(posedge clk); #1 rst = 1'b0;
        end
        run_vec(2, 1'b0);
        run_vec(1, 1'b0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
